// File: rtl/mem_responder_if.sv
// Purpose: processor <-> memory responder strobe bus (load and store channels).
// Latency: n/a (wires only); q is registered inside the responder.
// Backpressure: none; the strobe protocol has no ready signal, the master paces itself.
// Ports (signals carried):
//   read_addr/read_clock      read request; a rising read_clock asks for one word
//   q                         registered read data back to the master
//   write_addr/write_clock    write request; a rising write_clock asks for one store
//   data/we                   store data and enable (edges with we=0 are ignored)
interface mem_responder_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] read_addr;
  logic              read_clock;
  logic [WORD_W-1:0] q;
  logic [ADDR_W-1:0] write_addr;
  logic              write_clock;
  logic [WORD_W-1:0] data;
  logic              we;

  // processor side
  modport master (
    output read_addr, read_clock, write_addr, write_clock, data, we,
    input  q
  );

  // memory side
  modport slave (
    input  read_addr, read_clock, write_addr, write_clock, data, we,
    output q
  );
endinterface

// File: rtl/mem_responder.sv
// Purpose: strobe-driven memory responder; one word access per rising edge of read_clock/write_clock.
// Latency: q is updated on the clock edge that first samples read_clock high (1 cycle).
// Backpressure: none; every detected edge is served in the cycle it is seen.
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        asynchronous active-high reset (q, strobe history, MMIO registers)
//   bus          mem_responder_if.slave: read/write strobes, addresses, data, we, q
//   SW           18 board switches (asynchronous, MMIO builds only)
//   HEX0..HEX7   active-low 7-segment digits {g,f,e,d,c,b,a}, HEX0 least significant
//
// Build option: define MEM_RESPONDER_MMIO_EN to map address DEPTH-1 onto the
// synchronised switches (read-only) and DEPTH-2 onto the display register.
// Without it those addresses are ordinary words and the display is blank.
module mem_responder #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256   // must equal 2**ADDR_W, so addresses wrap naturally
) (
  input  logic              clock,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic [17:0]       SW,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX7
);

  // --------------------------------------------------------------------
  // Strobe edge detection
  // --------------------------------------------------------------------
  // The history flops come out of reset high so a strobe that is already
  // asserted when reset drops is treated as "old" and causes no access.
  // While reset is held they stay high, which also blocks any access
  // during reset.
  logic rd_q;
  logic wr_q;
  logic rd_edge;
  logic wr_edge;
  logic wr_fire;
  logic bypass;

  assign rd_edge = bus.read_clock  & ~rd_q;
  assign wr_edge = bus.write_clock & ~wr_q;
  assign wr_fire = wr_edge & bus.we;

  // Read and enabled write hitting the same address in the same cycle:
  // the reader sees the new data (write-first).
  assign bypass  = rd_edge & wr_fire & (bus.read_addr == bus.write_addr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b1;
      wr_q <= 1'b1;
    end else begin
      rd_q <= bus.read_clock;
      wr_q <= bus.write_clock;
    end
  end

  // --------------------------------------------------------------------
  // Word array (contents survive reset)
  // --------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [WORD_W-1:0] rd_word;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[bus.write_addr] <= bus.data;
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  // --------------------------------------------------------------------
  // Memory-mapped board I/O
  // --------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] HEX_ADDR = ADDR_W'(DEPTH - 2);

  logic [17:0]       sw_meta;
  logic [17:0]       sw_sync;
  logic [WORD_W-1:0] hex_reg;
  logic [31:0]       hex_view;

  // Two-flop synchroniser for the switches, plus the display register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      hex_reg <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (wr_fire && (bus.write_addr == HEX_ADDR)) begin
        hex_reg <= bus.data;
      end
    end
  end

  // Both mapped addresses are kept out of the array: the switch port is
  // read-only and the display register lives in its own flops.
  assign mem_we = wr_fire &&
                  (bus.write_addr != SW_ADDR) &&
                  (bus.write_addr != HEX_ADDR);

  always_comb begin
    rd_word = mem[bus.read_addr];
    if (bus.read_addr == SW_ADDR) begin
      rd_word = {{(WORD_W-18){1'b0}}, sw_sync};
    end else if (bus.read_addr == HEX_ADDR) begin
      rd_word = hex_reg;
    end
  end

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // The display shows the low 32 bits of the register, one nibble per digit.
  assign hex_view = 32'(hex_reg);

  assign HEX0 = seg7(hex_view[3:0]);
  assign HEX1 = seg7(hex_view[7:4]);
  assign HEX2 = seg7(hex_view[11:8]);
  assign HEX3 = seg7(hex_view[15:12]);
  assign HEX4 = seg7(hex_view[19:16]);
  assign HEX5 = seg7(hex_view[23:20]);
  assign HEX6 = seg7(hex_view[27:24]);
  assign HEX7 = seg7(hex_view[31:28]);
`else
  // --------------------------------------------------------------------
  // Plain memory: every address is an array word, display dark.
  // --------------------------------------------------------------------
  logic unused_sw;

  assign mem_we    = wr_fire;
  assign rd_word   = mem[bus.read_addr];
  assign unused_sw = ^SW;

  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
  assign HEX6 = 7'h7F;
  assign HEX7 = 7'h7F;
`endif

  // --------------------------------------------------------------------
  // Read data register: only reloads on a read edge, otherwise holds.
  // --------------------------------------------------------------------
  logic [WORD_W-1:0] q_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (rd_edge) begin
      q_r <= bypass ? bus.data : rd_word;
    end
  end

  assign bus.q = q_r;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] SW;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  mem_responder_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  mem_responder #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .SW    (SW),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5),
    .HEX6  (HEX6),
    .HEX7  (HEX7)
  );

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  // Transaction-level reference: what each word should hold and what q
  // should show after the most recent read request.
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_valid [DEPTH];
  logic [31:0] ref_q;
  logic [7:0]  last_wr;
  logic [31:0] ref_hex;
  logic [17:0] ref_sw;
  logic [6:0]  seg_exp [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_read(input logic [7:0] a);
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 8'hFF) return {14'b0, ref_sw};
    if (a == 8'hFE) return ref_hex;
`endif
    return ref_mem[a];
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [31:0] d);
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 8'hFF) return;
    if (a == 8'hFE) begin
      ref_hex = d;
      return;
    end
`endif
    ref_mem[a]   = d;
    ref_valid[a] = 1'b1;
    last_wr      = a;
  endtask

  task automatic check_display(input string tag, input logic [31:0] v);
    logic [55:0] hv;
    logic [3:0]  nib;
    hv = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    for (int k = 0; k < 8; k++) begin
      nib = v[4*k +: 4];
`ifdef MEM_RESPONDER_MMIO_EN
      check($sformatf("%s_hex%0d", tag, k), 32'(hv[7*k +: 7]), 32'(seg_exp[nib]));
`else
      check($sformatf("%s_hex%0d_%0h", tag, k, nib), 32'(hv[7*k +: 7]), 32'h7F);
`endif
    end
  endtask

  // One strobe episode: strobes rise together, stay high 'hold' cycles
  // (data drifts after the first cycle), then drop for one cycle.
  task automatic access(input string tag, input bit do_wr, input logic [7:0] wa,
                        input logic [31:0] wd, input bit wen, input bit do_rd,
                        input logic [7:0] ra, input int hold);
    logic [31:0] exp_q;
    exp_q = ref_q;
    if (do_rd) exp_q = (do_wr && wen && (wa == ra)) ? wd : ref_read(ra);
    if (do_wr && wen) ref_write(wa, wd);
    ref_q = exp_q;

    bus.write_addr = wa;
    bus.data       = wd;
    bus.we         = wen;
    bus.read_addr  = ra;
    if (do_wr) bus.write_clock = 1'b1;
    if (do_rd) bus.read_clock  = 1'b1;
    tick();
    check({tag, "_q"}, bus.q, exp_q);
    for (int k = 1; k < hold; k++) begin
      bus.data = wd + 32'(k);
      tick();
      check({tag, "_hold"}, bus.q, exp_q);
    end
    bus.write_clock = 1'b0;
    bus.read_clock  = 1'b0;
    tick();
  endtask

  initial begin
    int         kind;
    bit         wen;
    logic [7:0] wa, ra;
    logic [31:0] wd;
    int         hold;

    seg_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
    ref_q   = '0;
    ref_hex = '0;
    ref_sw  = '0;
    last_wr = 8'h10;

    reset           = 1'b1;
    SW              = '0;
    bus.read_addr   = '0;
    bus.read_clock  = 1'b0;
    bus.write_addr  = '0;
    bus.write_clock = 1'b0;
    bus.data        = '0;
    bus.we          = 1'b0;
    repeat (3) tick();
    check("reset_q", bus.q, 32'h0);
    check_display("reset", 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    // write then read
    access("t1_wr", 1, 8'h10, 32'hDEADBEEF, 1, 0, 8'h00, 1);
    access("t1_rd", 0, 8'h00, 32'h0, 0, 1, 8'h10, 1);

    // long write strobe, data ramps 1..5, only 1 lands
    access("t2_wr", 1, 8'h11, 32'h1, 1, 0, 8'h00, 5);
    access("t2_rd", 0, 8'h00, 32'h0, 0, 1, 8'h11, 3);

    // same-cycle collision, write-first
    access("t3_init", 1, 8'h20, 32'h0, 1, 0, 8'h00, 1);
    access("t3_coll", 1, 8'h20, 32'h12345678, 1, 1, 8'h20, 2);
    access("t3_rd",   0, 8'h00, 32'h0, 0, 1, 8'h20, 1);

    // write enable low: no store and no bypass
    access("t4_init", 1, 8'h30, 32'hA5A5A5A5, 1, 0, 8'h00, 1);
    access("t4_we0",  1, 8'h30, 32'h11111111, 0, 1, 8'h30, 1);
    access("t4_rd",   0, 8'h00, 32'h0, 0, 1, 8'h30, 1);

    // collision at different addresses
    access("t4_diff", 1, 8'h31, 32'h0BADCAFE, 1, 1, 8'h10, 1);
    access("t4_rd31", 0, 8'h00, 32'h0, 0, 1, 8'h31, 1);

`ifdef MEM_RESPONDER_MMIO_EN
    access("t6_hexwr", 1, 8'hFE, 32'h0123ABCD, 1, 0, 8'h00, 1);
    check_display("t6", 32'h0123ABCD);
    access("t6_hexrd", 0, 8'h00, 32'h0, 0, 1, 8'hFE, 1);
    SW = 18'h2A5A5;
    repeat (3) tick();
    ref_sw = 18'h2A5A5;
    access("t6_swrd", 0, 8'h00, 32'h0, 0, 1, 8'hFF, 1);
    access("t6_swwr", 1, 8'hFF, 32'hFFFFFFFF, 1, 0, 8'h00, 1);
    access("t6_swrd2", 0, 8'h00, 32'h0, 0, 1, 8'hFF, 1);
`else
    access("top_wr1", 1, 8'hFE, 32'hCAFEF00D, 1, 0, 8'h00, 1);
    access("top_wr0", 1, 8'hFF, 32'h600DF00D, 1, 0, 8'h00, 1);
    access("top_rd1", 0, 8'h00, 32'h0, 0, 1, 8'hFE, 1);
    access("top_rd0", 0, 8'h00, 32'h0, 0, 1, 8'hFF, 1);
    check_display("plain", 32'h0);
`endif

    // reset in the middle of a read strobe, with a write strobe raised during reset
    bus.read_addr  = 8'h10;
    bus.read_clock = 1'b1;
    tick();
    check("t5_pre", bus.q, ref_read(8'h10));
    bus.write_addr = 8'h10;
    bus.data       = 32'h0BAD0BAD;
    bus.we         = 1'b1;
    reset          = 1'b1;
    #1;
    check("t5_async", bus.q, 32'h0);
    ref_q   = '0;
    ref_hex = '0;
    bus.write_clock = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_held", bus.q, 32'h0);
    end
    bus.read_clock  = 1'b0;
    bus.write_clock = 1'b0;
    tick();
    check("t5_low", bus.q, 32'h0);
    access("t5_rd", 0, 8'h00, 32'h0, 0, 1, 8'h10, 1);
`ifdef MEM_RESPONDER_MMIO_EN
    check_display("t5", 32'h0);
    access("t5_hexrd", 0, 8'h00, 32'h0, 0, 1, 8'hFE, 1);
`endif

    // randomized traffic on a small address pool to force hits and collisions
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      wa   = 8'h40 + 8'($urandom_range(0, 15));
      ra   = 8'h40 + 8'($urandom_range(0, 15));
      wd   = $urandom;
      wen  = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 3);
      if (kind == 2 && $urandom_range(0, 1) == 1) ra = wa;
      if (!ref_valid[ra] && !(kind == 2 && wen && ra == wa)) ra = last_wr;
      case (kind)
        0:       access("rnd_wr",   1, wa, wd, wen, 0, ra, hold);
        1:       access("rnd_rd",   0, wa, wd, wen, 1, ra, hold);
        default: access("rnd_both", 1, wa, wd, wen, 1, ra, hold);
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
